// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared types and constants for the sprite fetch scheduler
package sprite_pkg;

    localparam int SPR_IMGW  = 2;
    localparam int SPR_DIM   = 16;
    localparam int SPR_SHIFT = 4;
    localparam int PIPE_LAT  = 3;

    typedef struct packed {
        logic                en;
        logic [9:0]          x;
        logic [9:0]          y;
        logic [SPR_IMGW-1:0] img;
    } sprite_cfg_t;

endpackage

// File: rtl/sprite_hit_test.sv
// rtl/sprite_hit_test.sv - one slot's 16x16 box compare and in-sprite offset
module sprite_hit_test
    import sprite_pkg::*;
(
    input  logic                 en,
    input  logic [9:0]           sx,
    input  logic [9:0]           sy,
    input  logic [9:0]           pix_x,
    input  logic [9:0]           pix_y,
    output logic                 hit,
    output logic [SPR_SHIFT-1:0] dx,
    output logic [SPR_SHIFT-1:0] dy
);

    logic [10:0] px;
    logic [10:0] py;
    logic [10:0] x0;
    logic [10:0] y0;

    // 11-bit compares keep boxes near the right/bottom edge from wrapping to 0
    always_comb begin
        px  = {1'b0, pix_x};
        py  = {1'b0, pix_y};
        x0  = {1'b0, sx};
        y0  = {1'b0, sy};
        hit = en && (px >= x0) && (px <= x0 + 11'(SPR_DIM - 1))
                 && (py >= y0) && (py <= y0 + 11'(SPR_DIM - 1));
        dx  = pix_x[SPR_SHIFT-1:0] - sx[SPR_SHIFT-1:0];
        dy  = pix_y[SPR_SHIFT-1:0] - sy[SPR_SHIFT-1:0];
    end

endmodule

// File: rtl/sprite_fetch_ctrl.sv
// rtl/sprite_fetch_ctrl.sv - per-pixel sprite hit test, priority pick and shared ROM fetch
module sprite_fetch_ctrl
    import sprite_pkg::*;
#(
    parameter  int               NSPR   = 4,
    parameter  int               IMGW   = SPR_IMGW,
    parameter  int               COLW   = 8,
    parameter  logic [COLW-1:0]  TRANSP = '0,
    localparam int               IDXW   = $clog2(NSPR)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              pix_valid,
    input  logic [9:0]        pix_x,
    input  logic [9:0]        pix_y,
    input  logic              cfg_we,
    input  logic [IDXW-1:0]   cfg_idx,
    input  logic              cfg_en,
    input  logic [9:0]        cfg_x,
    input  logic [9:0]        cfg_y,
    input  logic [IMGW-1:0]   cfg_img,
    output logic [IMGW+7:0]   rom_addr,
    output logic              rom_rd,
    input  logic [COLW-1:0]   rom_data,
    output logic              out_valid,
    output logic              out_hit,
    output logic [IDXW-1:0]   out_idx,
    output logic [COLW-1:0]   out_color
);

    sprite_cfg_t pend_bank [NSPR];
    sprite_cfg_t act_bank  [NSPR];
    sprite_cfg_t wr_cfg;

    logic [NSPR-1:0]      slot_hit;
    logic [SPR_SHIFT-1:0] slot_dx [NSPR];
    logic [SPR_SHIFT-1:0] slot_dy [NSPR];

    logic                 any_hit;
    logic [IDXW-1:0]      win_idx;
    logic [IMGW+7:0]      win_addr;

    logic                 s1_valid;
    logic [IDXW-1:0]      s1_idx;
    logic                 s2_valid;
    logic                 s2_hit;
    logic [IDXW-1:0]      s2_idx;
    logic                 opaque;

    always_comb begin
        wr_cfg     = '0;
        wr_cfg.en  = cfg_en;
        wr_cfg.x   = cfg_x;
        wr_cfg.y   = cfg_y;
        wr_cfg.img = SPR_IMGW'(cfg_img);
    end

    // A write landing in the commit cycle is forwarded so it is not lost for a frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSPR; i++) begin
                pend_bank[i] <= '0;
                act_bank[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NSPR; i++) begin
                if (cfg_we && cfg_idx == IDXW'(i))
                    pend_bank[i] <= wr_cfg;
                if (frame_start)
                    act_bank[i] <= (cfg_we && cfg_idx == IDXW'(i)) ? wr_cfg : pend_bank[i];
            end
        end
    end

    for (genvar g = 0; g < NSPR; g++) begin : g_slot
        sprite_hit_test u_hit (
            .en    (act_bank[g].en),
            .sx    (act_bank[g].x),
            .sy    (act_bank[g].y),
            .pix_x (pix_x),
            .pix_y (pix_y),
            .hit   (slot_hit[g]),
            .dx    (slot_dx[g]),
            .dy    (slot_dy[g])
        );
    end

    // Walk from the highest slot down so the lowest hitting index wins
    always_comb begin
        any_hit  = 1'b0;
        win_idx  = '0;
        win_addr = '0;
        for (int i = NSPR - 1; i >= 0; i--) begin
            if (slot_hit[i]) begin
                any_hit  = 1'b1;
                win_idx  = IDXW'(i);
                win_addr = {IMGW'(act_bank[i].img), slot_dy[i], slot_dx[i]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr <= '0;
            rom_rd   <= 1'b0;
            s1_valid <= 1'b0;
            s1_idx   <= '0;
        end else begin
            rom_rd   <= pix_valid & any_hit;
            s1_valid <= pix_valid;
            s1_idx   <= win_idx;
            if (pix_valid && any_hit)
                rom_addr <= win_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_hit   <= 1'b0;
            s2_idx   <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_hit   <= rom_rd;
            s2_idx   <= s1_idx;
        end
    end

    assign opaque = s2_valid && s2_hit && (rom_data != TRANSP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_hit   <= 1'b0;
            out_idx   <= '0;
            out_color <= '0;
        end else begin
            out_valid <= s2_valid;
            out_hit   <= opaque;
            out_idx   <= opaque ? s2_idx : '0;
            out_color <= opaque ? rom_data : '0;
        end
    end

endmodule

// File: tb/tb_sprite_fetch_ctrl.sv
// tb/tb_sprite_fetch_ctrl.sv - self-checking bench for sprite_fetch_ctrl
module tb_sprite_fetch_ctrl;

    localparam int NSPR = 4;
    localparam int IDXW = 2;
    localparam int IMGW = 2;
    localparam int COLW = 8;
    localparam logic [COLW-1:0] TRANSP = 8'h00;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            frame_start = 1'b0;
    logic            pix_valid = 1'b0;
    logic [9:0]      pix_x = '0;
    logic [9:0]      pix_y = '0;
    logic            cfg_we = 1'b0;
    logic [IDXW-1:0] cfg_idx = '0;
    logic            cfg_en = 1'b0;
    logic [9:0]      cfg_x = '0;
    logic [9:0]      cfg_y = '0;
    logic [IMGW-1:0] cfg_img = '0;
    logic [IMGW+7:0] rom_addr;
    logic            rom_rd;
    logic [COLW-1:0] rom_data = '0;
    logic            out_valid;
    logic            out_hit;
    logic [IDXW-1:0] out_idx;
    logic [COLW-1:0] out_color;

    sprite_fetch_ctrl #(.NSPR(NSPR), .IMGW(IMGW), .COLW(COLW), .TRANSP(TRANSP)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pix_valid(pix_valid),
        .pix_x(pix_x), .pix_y(pix_y), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
        .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_img(cfg_img), .rom_addr(rom_addr), .rom_rd(rom_rd),
        .rom_data(rom_data), .out_valid(out_valid), .out_hit(out_hit), .out_idx(out_idx),
        .out_color(out_color)
    );

    always #5 clk = ~clk;

    logic [COLW-1:0] rom_mem [1024];
    always @(posedge clk) if (rom_rd) rom_data <= rom_mem[rom_addr];

    typedef struct { int en; int x; int y; int img; } mcfg_t;
    typedef struct { bit v; bit h; int idx; int col; } mout_t;
    typedef struct {
        bit fs; bit pv; int px; int py;
        bit we; int idx; int en; int x; int y; int img;
        bit exp_rd; int exp_addr;
    } vec_t;

    mcfg_t pend_m [NSPR];
    mcfg_t act_m  [NSPR];
    mout_t out_q  [$];
    int    last_addr;
    int    n_cmp = 0;
    int    n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mout_t idle;
        idle = '{0, 0, 0, 0};
        for (int i = 0; i < NSPR; i++) begin
            pend_m[i] = '{0, 0, 0, 0};
            act_m[i]  = '{0, 0, 0, 0};
        end
        last_addr = 0;
        out_q.delete();
        out_q.push_back(idle);
        out_q.push_back(idle);
    endtask

    task automatic step(input bit fs, input bit pv, input int px, input int py,
                        input bit we, input int idx, input int en, input int x, input int y,
                        input int img, output bit e_rd, output int e_addr);
        bit    found;
        int    w;
        int    addr;
        mout_t o;
        mout_t g;
        frame_start = fs;
        pix_valid   = pv;
        pix_x       = 10'(px);
        pix_y       = 10'(py);
        cfg_we      = we;
        cfg_idx     = IDXW'(idx);
        cfg_en      = en[0];
        cfg_x       = 10'(x);
        cfg_y       = 10'(y);
        cfg_img     = IMGW'(img);
        found = 0; w = 0; addr = 0;
        for (int i = 0; i < NSPR; i++) begin
            if (!found && act_m[i].en != 0 &&
                px >= act_m[i].x && px <= act_m[i].x + 15 &&
                py >= act_m[i].y && py <= act_m[i].y + 15) begin
                found = 1;
                w     = i;
                addr  = act_m[i].img * 256 + (py - act_m[i].y) * 16 + (px - act_m[i].x);
            end
        end
        e_rd = pv && found;
        if (e_rd) last_addr = addr;
        e_addr = last_addr;
        o.v   = pv;
        o.h   = e_rd && (rom_mem[addr] != TRANSP);
        o.idx = o.h ? w : 0;
        o.col = o.h ? int'(rom_mem[addr]) : 0;
        @(posedge clk);
        #1;
        if (we) pend_m[idx] = '{en, x, y, img};
        if (fs) for (int i = 0; i < NSPR; i++) act_m[i] = pend_m[i];
        chk("rom_rd", 32'(rom_rd), 32'(e_rd));
        chk("rom_addr", 32'(rom_addr), 32'(e_addr));
        out_q.push_back(o);
        g = out_q.pop_front();
        chk("out_valid", 32'(out_valid), 32'(g.v));
        chk("out_hit", 32'(out_hit), 32'(g.h));
        chk("out_idx", 32'(out_idx), 32'(g.idx));
        chk("out_color", 32'(out_color), 32'(g.col));
    endtask

    task automatic idle_step();
        bit r; int a;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, r, a);
    endtask

    vec_t tbl [21];

    initial begin
        bit r;
        int a;
        int s;
        int px;
        int py;

        for (int i = 0; i < 1024; i++)
            rom_mem[i] = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        rom_mem[12'h123] = 8'h5A;
        rom_mem[12'h100] = TRANSP;
        rom_mem[12'h1AA] = 8'h11;
        rom_mem[12'h225] = 8'h22;
        rom_mem[12'h303] = 8'h33;
        rom_mem[12'h3F3] = 8'h44;
        rom_mem[12'h1FF] = 8'h77;

        //         fs pv  px    py   we idx en  x     y   img rd addr
        tbl[0]  = '{0, 0, 0,    0,   1, 0, 1, 100,  50,  1, 0, 12'h000};
        tbl[1]  = '{1, 0, 0,    0,   0, 0, 0, 0,    0,   0, 0, 12'h000};
        tbl[2]  = '{0, 1, 103,  52,  0, 0, 0, 0,    0,   0, 1, 12'h123};
        tbl[3]  = '{0, 0, 0,    0,   1, 0, 1, 190,  190, 1, 0, 12'h123};
        tbl[4]  = '{1, 0, 0,    0,   1, 2, 1, 195,  198, 2, 0, 12'h123};
        tbl[5]  = '{0, 1, 200,  200, 0, 0, 0, 0,    0,   0, 1, 12'h1AA};
        tbl[6]  = '{1, 0, 0,    0,   1, 0, 0, 190,  190, 1, 0, 12'h1AA};
        tbl[7]  = '{0, 1, 200,  200, 0, 0, 0, 0,    0,   0, 1, 12'h225};
        tbl[8]  = '{1, 0, 0,    0,   1, 1, 1, 1020, 0,   3, 0, 12'h225};
        tbl[9]  = '{0, 1, 1023, 0,   0, 0, 0, 0,    0,   0, 1, 12'h303};
        tbl[10] = '{0, 1, 5,    0,   0, 0, 0, 0,    0,   0, 0, 12'h303};
        tbl[11] = '{0, 1, 1023, 15,  0, 0, 0, 0,    0,   0, 1, 12'h3F3};
        tbl[12] = '{0, 1, 1023, 16,  0, 0, 0, 0,    0,   0, 0, 12'h3F3};
        tbl[13] = '{1, 0, 0,    0,   1, 0, 1, 100,  50,  1, 0, 12'h3F3};
        tbl[14] = '{0, 1, 103,  52,  0, 0, 0, 0,    0,   0, 1, 12'h123};
        tbl[15] = '{0, 0, 0,    0,   1, 0, 1, 300,  300, 1, 0, 12'h123};
        tbl[16] = '{0, 1, 103,  52,  0, 0, 0, 0,    0,   0, 1, 12'h123};
        tbl[17] = '{1, 0, 0,    0,   0, 0, 0, 0,    0,   0, 0, 12'h123};
        tbl[18] = '{0, 1, 103,  52,  0, 0, 0, 0,    0,   0, 0, 12'h123};
        tbl[19] = '{0, 1, 300,  300, 0, 0, 0, 0,    0,   0, 1, 12'h100};
        tbl[20] = '{0, 1, 315,  315, 0, 0, 0, 0,    0,   0, 1, 12'h1FF};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_rom_addr", 32'(rom_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 21; k++) begin
            step(tbl[k].fs, tbl[k].pv, tbl[k].px, tbl[k].py, tbl[k].we, tbl[k].idx,
                 tbl[k].en, tbl[k].x, tbl[k].y, tbl[k].img, r, a);
            chk($sformatf("tbl%0d_rd", k), 32'(rom_rd), 32'(tbl[k].exp_rd));
            chk($sformatf("tbl%0d_addr", k), 32'(rom_addr), 32'(tbl[k].exp_addr));
        end
        repeat (3) idle_step();

        // Back-to-back pixels across slot0's box at (300,300)
        for (int k = 0; k < 64; k++)
            step(0, 1, 296 + (k % 24), 298 + (k / 8), 0, 0, 0, 0, 0, 0, r, a);
        repeat (3) idle_step();

        for (int k = 0; k < 1500; k++) begin
            s = $urandom_range(0, NSPR - 1);
            if ($urandom_range(0, 3) != 0) begin
                px = (act_m[s].x + $urandom_range(0, 19) + 1022) % 1024;
                py = (act_m[s].y + $urandom_range(0, 19) + 1022) % 1024;
            end else begin
                px = $urandom_range(0, 1023);
                py = $urandom_range(0, 1023);
            end
            step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, px, py,
                 $urandom_range(0, 3) == 0, $urandom_range(0, NSPR - 1),
                 int'($urandom_range(0, 3) != 0), $urandom_range(0, 1023),
                 $urandom_range(0, 1023), $urandom_range(0, 3), r, a);
        end
        repeat (3) idle_step();

        // Asynchronous reset with three pixels still in the pipe
        step(1, 0, 0, 0, 1, 0, 1, 400, 400, 2, r, a);
        step(0, 1, 401, 401, 0, 0, 0, 0, 0, 0, r, a);
        step(0, 1, 402, 402, 0, 0, 0, 0, 0, 0, r, a);
        step(0, 1, 403, 403, 0, 0, 0, 0, 0, 0, r, a);
        pix_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rom_rd", 32'(rom_rd), 32'd0);
        chk("arst_rom_addr", 32'(rom_addr), 32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_hit", 32'(out_hit), 32'd0);
        chk("arst_out_idx", 32'(out_idx), 32'd0);
        chk("arst_out_color", 32'(out_color), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (4) idle_step();
        step(0, 1, 401, 401, 0, 0, 0, 0, 0, 0, r, a);
        step(0, 1, 5, 5, 0, 0, 0, 0, 0, 0, r, a);
        repeat (4) idle_step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
